// File: rtl/phase_oscillator.sv
// Per-voice timebase: free-running period counter plus an 8-bit phase ramp spread
// evenly over each period by a fractional (Bresenham) accumulator.
module phase_oscillator #(
    parameter int CNT_W   = 19,
    parameter int Q_W     = 8,
    parameter int MIN_DIV = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic [CNT_W-1:0] divisor_in,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] divisor,
    output logic [Q_W-1:0]   Q,
    output logic             period_tick
);

    localparam logic [CNT_W:0]   STEP  = (CNT_W+1)'(1) << Q_W;
    localparam logic [CNT_W-1:0] MIN_D = CNT_W'(MIN_DIV);

    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] eff_div;
    logic [CNT_W:0]   sum;
    logic [CNT_W:0]   diff;
    logic             take;
    logic             wrap;
    logic             idle;

    // Requests below the minimum would need more than one ramp step per cycle.
    always_comb begin
        eff_div = divisor_in;
        if (divisor_in == '0)
            eff_div = '0;
        else if (divisor_in < MIN_D)
            eff_div = MIN_D;
    end

    assign idle = (divisor == '0);
    assign sum  = {1'b0, acc} + STEP;
    assign diff = sum - {1'b0, divisor};
    assign take = (sum >= {1'b0, divisor});
    assign wrap = (count == divisor - CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            divisor     <= '0;
            Q           <= '0;
            acc         <= '0;
            period_tick <= 1'b0;
        end else if (sync || idle) begin
            // Hard restart, or leaving idle: the new period starts from zero phase.
            count       <= '0;
            acc         <= '0;
            Q           <= '0;
            divisor     <= eff_div;
            period_tick <= 1'b0;
        end else if (en) begin
            if (wrap) begin
                // Frequency changes are only picked up here so the ramp never glitches.
                count       <= '0;
                acc         <= '0;
                Q           <= '0;
                divisor     <= eff_div;
                period_tick <= 1'b1;
            end else begin
                count       <= count + CNT_W'(1);
                period_tick <= 1'b0;
                if (take) begin
                    acc <= diff[CNT_W-1:0];
                    Q   <= Q + Q_W'(1);
                end else begin
                    acc <= sum[CNT_W-1:0];
                end
            end
        end else begin
            period_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_phase_oscillator.sv
// Bench for phase_oscillator: per-cycle expected outputs go into a queue, a negedge
// monitor pops and compares; directed checks cover the headline scenarios.
module tb_phase_oscillator;

    localparam int W = 47;

    logic        clk;
    logic        rst;
    logic        en;
    logic        sync;
    logic [18:0] divisor_in;
    logic [18:0] count;
    logic [18:0] divisor;
    logic [7:0]  Q;
    logic        period_tick;

    phase_oscillator dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .divisor_in(divisor_in),
        .count(count), .divisor(divisor), .Q(Q), .period_tick(period_tick)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_tick_cyc = 0;
    int tick_gap = 0;
    int tick_cnt = 0;

    // bench model: period bookkeeping, phase from closed form floor(256*count/divisor)
    logic [18:0] m_cnt = '0;
    logic [18:0] m_div = '0;
    logic        m_tick = 1'b0;
    logic [7:0]  m_q = '0;

    function automatic logic [18:0] clamp(input logic [18:0] d);
        if (d == 0) return 19'd0;
        if (d < 19'd256) return 19'd256;
        return d;
    endfunction

    task automatic model_next();
        logic [18:0] eff;
        int ph;
        eff = clamp(divisor_in);
        if (rst) begin
            m_cnt = '0; m_div = '0; m_tick = 1'b0;
        end else if (sync || m_div == 0) begin
            m_cnt = '0; m_div = eff; m_tick = 1'b0;
        end else if (en) begin
            if (m_cnt == m_div - 1) begin
                m_cnt = '0; m_div = eff; m_tick = 1'b1;
            end else begin
                m_cnt = m_cnt + 1; m_tick = 1'b0;
            end
        end else begin
            m_tick = 1'b0;
        end
        ph = (m_div == 0) ? 0 : (int'(m_cnt) * 256) / int'(m_div);
        m_q = ph[7:0];
    endtask

    // driver: inputs change just after a rising edge
    task automatic step(input logic e, input logic s, input logic [18:0] d);
        en = e; sync = s; divisor_in = d;
        model_next();
        @(posedge clk);
        exp_q.push_back({m_tick, m_div, m_cnt, m_q});
        #1;
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out, got none expected event", name);
    endtask

    task automatic run_until_count(input int target, input logic [18:0] d);
        bit hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            if (int'(m_cnt) == target) hit = 1'b1;
            else step(1'b1, 1'b0, d);
        end
        if (!hit) timeout("run_until_count");
    endtask

    task automatic run_until_tick(input logic [18:0] d);
        bit hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            step(1'b1, 1'b0, d);
            hit = m_tick;
        end
        if (!hit) timeout("run_until_tick");
    endtask

    task automatic chk_gap(input string name, input int expv);
        @(negedge clk);
        #1;
        chk(name, tick_gap, expv);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        cyc++;
        if (period_tick === 1'b1) begin
            tick_gap = cyc - last_tick_cyc;
            last_tick_cyc = cyc;
            tick_cnt++;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {period_tick, divisor, count, Q};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL scoreboard cyc=%0d got tick=%0b div=%0d cnt=%0d q=%0d expected tick=%0b div=%0d cnt=%0d q=%0d",
                         cyc, a[46], a[45:27], a[26:8], a[7:0], e[46], e[45:27], e[26:8], e[7:0]);
            end
        end
    end

    initial begin
        int saved;
        rst = 1'b0; en = 1'b0; sync = 1'b0; divisor_in = '0;
        #1 rst = 1'b1;
        #2;
        chk("reset_count", int'(count), 0);
        chk("reset_divisor", int'(divisor), 0);
        chk("reset_q", int'(Q), 0);
        chk("reset_tick", int'(period_tick), 0);
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 19'd0);
        rst = 1'b0;

        // 512-cycle period
        step(1'b1, 1'b0, 19'd512);
        chk("load_divisor_512", int'(divisor), 512);
        step(1'b1, 1'b0, 19'd512);
        step(1'b1, 1'b0, 19'd512);
        chk("q_after_two_edges", int'(Q), 1);
        run_until_count(256, 19'd512);
        chk("q_mid_period", int'(Q), 128);
        run_until_tick(19'd512);
        chk("wrap_q_zero", int'(Q), 0);
        run_until_tick(19'd512);
        chk_gap("gap_512", 512);

        // mid-period change to 1024 waits for the wrap
        run_until_count(100, 19'd512);
        run_until_tick(19'd1024);
        chk("divisor_1024_after_wrap", int'(divisor), 1024);
        run_until_tick(19'd1024);
        chk_gap("gap_1024", 1024);

        // clamp 100 -> 256
        run_until_tick(19'd100);
        chk("clamp_divisor", int'(divisor), 256);
        run_until_tick(19'd100);
        chk_gap("gap_256", 256);

        // 300: every ramp value once, uneven spacing
        run_until_tick(19'd300);
        chk("divisor_300", int'(divisor), 300);
        run_until_tick(19'd300);
        chk_gap("gap_300", 300);

        // enable held low for 37 cycles mid-period
        run_until_count(150, 19'd300);
        repeat (37) step(1'b0, 1'b0, 19'd300);
        chk("frozen_count", int'(count), 150);
        chk("frozen_q", int'(Q), 128);
        run_until_tick(19'd300);
        chk_gap("gap_with_stall", 337);

        // sync mid-period
        run_until_count(200, 19'd300);
        step(1'b1, 1'b1, 19'd512);
        chk("sync_count", int'(count), 0);
        chk("sync_q", int'(Q), 0);
        chk("sync_divisor", int'(divisor), 512);
        chk("sync_tick", int'(period_tick), 0);

        // sync coinciding with a wrap suppresses the tick
        run_until_count(511, 19'd512);
        step(1'b1, 1'b1, 19'd512);
        chk("sync_on_wrap_tick", int'(period_tick), 0);
        chk("sync_on_wrap_count", int'(count), 0);

        // asynchronous reset mid-cycle
        run_until_count(400, 19'd512);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_q", int'(Q), 0);
        chk("async_rst_divisor", int'(divisor), 0);
        step(1'b1, 1'b0, 19'd512);
        step(1'b1, 1'b0, 19'd512);
        rst = 1'b0;

        // voice off at the wrap: block goes idle
        step(1'b1, 1'b0, 19'd512);
        run_until_count(10, 19'd512);
        run_until_tick(19'd0);
        chk("idle_divisor", int'(divisor), 0);
        @(negedge clk);
        #1 saved = tick_cnt;
        repeat (20) step(1'b1, 1'b0, 19'd0);
        chk("idle_no_ticks", tick_cnt, saved);
        chk("idle_count", int'(count), 0);
        chk("idle_q", int'(Q), 0);

        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
